// File: rtl/spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI master among N_REQ requesters.
// Issues one 16-bit command per grant, returns the response, and aborts on a missing done.
module spi_arb #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  cmd_in,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     rdy,
    output logic [N_REQ-1:0]     err,
    output logic [15:0]          rsp_data,
    output logic                 busy,
    output logic                 wrt,
    output logic [15:0]          cmd,
    input  logic                 done,
    input  logic [15:0]          rd_data,
    output logic [1:0]           state_dbg
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE = 1;
    localparam logic [IW-1:0]    LAST = IW'(N_REQ - 1);
    localparam logic [CW-1:0]    TERM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    logic          found;
    logic [CW-1:0] cnt;

    assign state_dbg = state;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            cnt      <= '0;
            ack      <= '0;
            rdy      <= '0;
            err      <= '0;
            wrt      <= 1'b0;
            cmd      <= '0;
            rsp_data <= '0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            rdy <= '0;
            err <= '0;
            wrt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        idx   <= sel;
                        cmd   <= cmd_in[16*sel +: 16];
                        wrt   <= 1'b1;
                        ack   <= ONE << sel;
                        busy  <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    ptr   <= (idx == LAST) ? '0 : idx + 1'b1;
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done wins over the terminal count in the same cycle.
                    if (done) begin
                        rsp_data <= rd_data;
                        rdy      <= ONE << idx;
                        state    <= GAP;
                    end else if (cnt == TERM) begin
                        err      <= ONE << idx;
                        state    <= GAP;
                    end else begin
                        cnt      <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
